apb_requester: RTL

Single-outstanding APB4 requester (master) that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns a registered response. It sits between test/CPU-side logic and APB completers such as the register-configured sync FIFO:
- PADDR[31]=0 addresses the completer's registers.
- PADDR[31]=1 addresses its data port.

A PREADY wait-state timeout keeps a hung completer from stalling the requester.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_requester.sv | 121 ++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its completers.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_req_state_e;

  // Command as latched at acceptance time.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } apb_cmd_t;

  // PADDR[31] selects the completer's data port; clear selects its registers.
  localparam int unsigned APB_FIFO_SEL_BIT   = 31;
  localparam logic [31:0] APB_DEPTH_REG_ADDR = 32'h0;

endpackage

// File: rtl/apb_requester.sv
// Single-outstanding APB4 requester: valid/ready command in, registered response out,
// with a PREADY wait-state timeout so a hung completer cannot stall the requester.
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16  // legal range 1..65535
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  input  logic [2:0]  cmd_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] PADDR,
  output logic [2:0]  PPROT,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);

  localparam logic [16:0] TimeoutW = 17'(TIMEOUT);

  apb_req_state_e state;
  apb_cmd_t       cmd_q;
  logic [15:0]    wait_cnt;
  logic           wait_limit;

  // Byte-lane bits of the address never reach the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  // This ACCESS cycle is the last one allowed with PREADY low.
  assign wait_limit = (({1'b0, wait_cnt} + 17'd1) == TimeoutW);

  assign cmd_ready = (state == IDLE);

  // Bus fields come straight from the latch, so they hold across IDLE/RESP.
  assign PADDR  = cmd_q.addr;
  assign PWRITE = cmd_q.write;
  assign PWDATA = cmd_q.wdata;
  assign PSTRB  = cmd_q.strb;
  assign PPROT  = cmd_q.prot;

  // Transfer FSM with command latch, wait counter and registered response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      cmd_q       <= '0;
      wait_cnt    <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q.write <= cmd_write;
            cmd_q.addr  <= {cmd_addr[31:2], 2'b00};
            cmd_q.wdata <= cmd_wdata;
            cmd_q.strb  <= cmd_write ? cmd_strb : 4'b0000;
            cmd_q.prot  <= cmd_prot;
            PSEL        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= cmd_q.write ? 32'h0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else if (wait_limit) begin
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
